// File: rtl/rom_pipe.sv
// rom_pipe: pipelined lookup ROM with valid/ready request and response channels.
// Requests carry a tag, and a credit-guarded response FIFO absorbs downstream stalls.
module rom_pipe #(
  parameter int DW   = 16,
  parameter int AW   = 8,
  parameter int TW   = 4,
  parameter int LAT  = 2,
  parameter int MODE = 0
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [TW-1:0] req_tag,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [TW-1:0] rsp_tag,
  output logic          busy
);

  localparam int CAP = LAT + 1;
  localparam int CW  = $clog2(CAP + 1);
  localparam logic [CW-1:0] CAP_C = CW'(CAP);

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("rom_pipe: MODE must be 0, 1 or 2");
  end
  if (LAT < 1 || LAT > 4) begin : g_bad_lat
    $error("rom_pipe: LAT must be in 1..4");
  end
  if (DW < 1 || DW > 64 || AW < 1 || AW > 12 || TW < 1 || TW > 16) begin : g_bad_width
    $error("rom_pipe: DW, AW or TW out of range");
  end

  // Word i is f(i) evaluated in AW bits, then resized (zero-extend or truncate) to DW.
  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [AW-1:0] w;
    case (MODE)
      1:       w = ~a;
      2:       w = a ^ (a >> 1);
      default: w = a;
    endcase
    return DW'(w);
  endfunction

  logic          acc;
  logic          pop;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic [DW-1:0] fdat_q [CAP];
  logic [DW-1:0] fdat_d [CAP];
  logic [TW-1:0] ftag_q [CAP];
  logic [TW-1:0] ftag_d [CAP];
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [TW-1:0] wr_tag;

  assign acc       = req_valid && req_ready;
  assign pop       = rsp_valid && rsp_ready;
  // Credits cover pipeline plus FIFO, so ready depends only on the registered count.
  assign req_ready = (cnt_q != CAP_C);
  assign busy      = (cnt_q != '0);
  assign rsp_valid = (fcnt_q != '0);
  assign rsp_data  = fdat_q[0];
  assign rsp_tag   = ftag_q[0];

  always_comb begin
    cnt_d = cnt_q;
    if (acc && !pop) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!acc && pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Stage boundary: ROM read -> free-running pipeline (or straight into the FIFO).
  if (LAT == 1) begin : g_direct
    assign wr_en   = acc;
    assign wr_data = rom_word(req_addr);
    assign wr_tag  = req_tag;
  end else begin : g_pipe
    localparam int NS = LAT - 1;
    logic          vld_q [NS];
    logic [DW-1:0] dat_q [NS];
    logic [TW-1:0] tag_q [NS];

    always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
        for (int s = 0; s < NS; s++) vld_q[s] <= 1'b0;
      end else begin
        vld_q[0] <= acc;
        for (int s = 1; s < NS; s++) vld_q[s] <= vld_q[s-1];
      end
    end

    always_ff @(posedge clk) begin
      dat_q[0] <= rom_word(req_addr);
      tag_q[0] <= req_tag;
      for (int s = 1; s < NS; s++) begin
        dat_q[s] <= dat_q[s-1];
        tag_q[s] <= tag_q[s-1];
      end
    end

    assign wr_en   = vld_q[NS-1];
    assign wr_data = dat_q[NS-1];
    assign wr_tag  = tag_q[NS-1];
  end

  // Stage boundary: shift-register FIFO; the head sits in entry 0 so outputs come from flops.
  always_comb begin
    fcnt_d = fcnt_q;
    for (int e = 0; e < CAP; e++) begin
      fdat_d[e] = fdat_q[e];
      ftag_d[e] = ftag_q[e];
    end
    if (pop) begin
      for (int e = 0; e < CAP - 1; e++) begin
        fdat_d[e] = fdat_q[e+1];
        ftag_d[e] = ftag_q[e+1];
      end
      fcnt_d = fcnt_q - CW'(1);
    end
    if (wr_en) begin
      for (int e = 0; e < CAP; e++) begin
        if (CW'(e) == fcnt_d) begin
          fdat_d[e] = wr_data;
          ftag_d[e] = wr_tag;
        end
      end
      fcnt_d = fcnt_d + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q  <= '0;
      fcnt_q <= '0;
      for (int e = 0; e < CAP; e++) begin
        fdat_q[e] <= '0;
        ftag_q[e] <= '0;
      end
    end else begin
      cnt_q  <= cnt_d;
      fcnt_q <= fcnt_d;
      for (int e = 0; e < CAP; e++) begin
        fdat_q[e] <= fdat_d[e];
        ftag_q[e] <= ftag_d[e];
      end
    end
  end

endmodule

// File: tb/tb_rom_pipe.sv
// Bench for rom_pipe: four configurations share one stimulus stream; each has its own
// transaction-level model (ordered queue of accepted requests with their accept edge).
module tb_rom_pipe;

  localparam int NI = 4;
  localparam int LATS  [NI] = '{2, 4, 1, 3};
  localparam int MODES [NI] = '{0, 2, 1, 2};
  localparam int DWS   [NI] = '{16, 16, 16, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          nreset;
  logic          req_valid;
  logic [7:0]    req_addr;
  logic [3:0]    req_tag;
  logic          rsp_ready;
  logic [NI-1:0] rv, rr, bz;
  logic [15:0]   rd0, rd1, rd2;
  logic [3:0]    rd3;
  logic [3:0]    rt0, rt1, rt2, rt3;

  rom_pipe #(.DW(16), .AW(8), .TW(4), .LAT(2), .MODE(0)) u_main (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(rr[0]),
    .req_addr(req_addr), .req_tag(req_tag), .rsp_valid(rv[0]), .rsp_ready(rsp_ready),
    .rsp_data(rd0), .rsp_tag(rt0), .busy(bz[0]));
  rom_pipe #(.DW(16), .AW(8), .TW(4), .LAT(4), .MODE(2)) u_lat4 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(rr[1]),
    .req_addr(req_addr), .req_tag(req_tag), .rsp_valid(rv[1]), .rsp_ready(rsp_ready),
    .rsp_data(rd1), .rsp_tag(rt1), .busy(bz[1]));
  rom_pipe #(.DW(16), .AW(8), .TW(4), .LAT(1), .MODE(1)) u_lat1 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(rr[2]),
    .req_addr(req_addr), .req_tag(req_tag), .rsp_valid(rv[2]), .rsp_ready(rsp_ready),
    .rsp_data(rd2), .rsp_tag(rt2), .busy(bz[2]));
  rom_pipe #(.DW(4), .AW(8), .TW(4), .LAT(3), .MODE(2)) u_dw4 (
    .clk(clk), .nreset(nreset), .req_valid(req_valid), .req_ready(rr[3]),
    .req_addr(req_addr), .req_tag(req_tag), .rsp_valid(rv[3]), .rsp_ready(rsp_ready),
    .rsp_data(rd3), .rsp_tag(rt3), .busy(bz[3]));

  int     checks, errors;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int     qa [NI][8];
  int     qt [NI][8];
  longint qk [NI][8];
  int     qh [NI];
  int     qn [NI];

  int     s_nr, s_drops, s_bad;
  longint s_first, s_last;

  function automatic int rdata(input int i);
    case (i)
      0:       return int'(rd0);
      1:       return int'(rd1);
      2:       return int'(rd2);
      default: return int'(rd3);
    endcase
  endfunction

  function automatic int rtag(input int i);
    case (i)
      0:       return int'(rt0);
      1:       return int'(rt1);
      2:       return int'(rt2);
      default: return int'(rt3);
    endcase
  endfunction

  function automatic int exp_word(input int mode, input int dw, input int a);
    int f;
    case (mode)
      0:       f = a;
      1:       f = 255 - a;
      default: f = a ^ (a / 2);
    endcase
    return f % (1 << dw);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle model: a request accepted on edge k is visible after edge k+LAT-1.
  task automatic model_cycle();
    for (int i = 0; i < NI; i++) begin
      int cap;
      int h;
      bit ev;
      bit pop;
      bit acc;
      cap = LATS[i] + 1;
      if (!nreset) begin
        qn[i] = 0;
        qh[i] = 0;
        chk($sformatf("u%0d reset rsp_valid", i), 64'(rv[i]), 64'(0));
        chk($sformatf("u%0d reset req_ready", i), 64'(rr[i]), 64'(1));
        chk($sformatf("u%0d reset busy", i), 64'(bz[i]), 64'(0));
        chk($sformatf("u%0d reset rsp_data", i), 64'(rdata(i)), 64'(0));
        chk($sformatf("u%0d reset rsp_tag", i), 64'(rtag(i)), 64'(0));
      end else begin
        h  = qh[i];
        ev = (qn[i] > 0) && (cyc >= qk[i][h] + longint'(LATS[i] - 1));
        chk($sformatf("u%0d rsp_valid", i), 64'(rv[i]), 64'(ev));
        chk($sformatf("u%0d req_ready", i), 64'(rr[i]), 64'(qn[i] != cap));
        chk($sformatf("u%0d busy", i), 64'(bz[i]), 64'(qn[i] != 0));
        if (ev && rv[i]) begin
          chk($sformatf("u%0d rsp_data", i), 64'(rdata(i)),
              64'(exp_word(MODES[i], DWS[i], qa[i][h])));
          chk($sformatf("u%0d rsp_tag", i), 64'(rtag(i)), 64'(qt[i][h]));
        end
        pop = ev && rsp_ready;
        acc = req_valid && rr[i];
        if (pop) begin
          qh[i] = (qh[i] + 1) % 8;
          qn[i]--;
        end
        if (acc) begin
          chk($sformatf("u%0d no overflow", i), 64'(qn[i] < cap), 64'(1));
          h = (qh[i] + qn[i]) % 8;
          qa[i][h] = int'(req_addr);
          qt[i][h] = int'(req_tag);
          qk[i][h] = cyc + 1;
          qn[i]++;
        end
      end
    end
  endtask

  task automatic single(input int inst, input logic [7:0] a, input logic [3:0] t,
                        output int d, output int tg, output int lat, output int nr);
    d = 0; tg = 0; lat = -1; nr = 0;
    req_valid = 1'b1; req_addr = a; req_tag = t; rsp_ready = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      tick();
      req_valid = 1'b0;
      @(negedge clk);
      if (rv[inst]) begin
        if (lat < 0) begin
          lat = n; d = rdata(inst); tg = rtag(inst);
        end
        nr++;
      end
    end
  endtask

  task automatic sweep_obs();
    if (!rr[0]) s_drops++;
    if (rv[0]) begin
      if (rd0 != 16'(s_nr) || rt0 != 4'(s_nr)) s_bad++;
      if (s_first < 0) s_first = cyc;
      s_last = cyc;
      s_nr++;
    end
  endtask

  initial begin
    int d, tg, lat, nr, idx, ng, rr_c0, rr_c1;
    int got [8];
    nreset = 1'b0; req_valid = 1'b0; req_addr = '0; req_tag = '0; rsp_ready = 1'b0;
    checks = 0; errors = 0;
    fork
      forever begin
        @(negedge clk);
        model_cycle();
      end
      begin
        repeat (2) tick();
        @(negedge clk);
        chk("reset req_ready", 64'(rr[0]), 64'(1));
        chk("reset busy", 64'(bz[0]), 64'(0));
        tick();
        nreset = 1'b1;
        tick();

        single(0, 8'h05, 4'h3, d, tg, lat, nr);
        chk("single latency", 64'(lat), 64'(2));
        chk("single data", 64'(d), 64'h0005);
        chk("single tag", 64'(tg), 64'h3);
        chk("single count", 64'(nr), 64'(1));
        chk("single busy after", 64'(bz[0]), 64'(0));
        tick();

        single(2, 8'h03, 4'h9, d, tg, lat, nr);
        chk("mode1 latency", 64'(lat), 64'(1));
        chk("mode1 data", 64'(d), 64'h00FC);
        chk("mode1 tag", 64'(tg), 64'h9);
        tick();
        single(1, 8'h0B, 4'hA, d, tg, lat, nr);
        chk("mode2 latency", 64'(lat), 64'(4));
        chk("mode2 data", 64'(d), 64'h000E);
        tick();
        single(3, 8'hFF, 4'h1, d, tg, lat, nr);
        chk("mode2 dw4 latency", 64'(lat), 64'(3));
        chk("mode2 dw4 data", 64'(d), 64'h0);
        tick();

        s_nr = 0; s_drops = 0; s_bad = 0; s_first = -1; s_last = -1;
        for (int i = 0; i < 256; i++) begin
          req_valid = 1'b1; req_addr = 8'(i); req_tag = 4'(i); rsp_ready = 1'b1;
          @(negedge clk);
          sweep_obs();
          tick();
        end
        req_valid = 1'b0;
        repeat (6) begin
          @(negedge clk);
          sweep_obs();
          tick();
        end
        chk("sweep responses", 64'(s_nr), 64'(256));
        chk("sweep ready drops", 64'(s_drops), 64'(0));
        chk("sweep order", 64'(s_bad), 64'(0));
        chk("sweep contiguous", 64'(s_last - s_first), 64'(255));

        idx = 0; rsp_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
          req_valid = 1'b1; req_addr = 8'h10 + 8'(idx); req_tag = 4'(idx);
          @(negedge clk);
          if (rr[0]) idx++;
          tick();
        end
        @(negedge clk);
        chk("bp accepted", 64'(idx), 64'(3));
        chk("bp req_ready", 64'(rr[0]), 64'(0));
        chk("bp busy", 64'(bz[0]), 64'(1));
        tick();
        ng = 0; rr_c0 = -1; rr_c1 = -1;
        for (int c = 0; c < 12; c++) begin
          req_valid = (idx < 4); req_addr = 8'h10 + 8'(idx); req_tag = 4'(idx);
          rsp_ready = 1'b1;
          @(negedge clk);
          if (c == 0) rr_c0 = int'(rr[0]);
          if (c == 1) rr_c1 = int'(rr[0]);
          if (rv[0] && ng < 8) begin
            got[ng] = int'(rd0);
            ng++;
          end
          if (req_valid && rr[0]) idx++;
          tick();
        end
        req_valid = 1'b0;
        chk("bp ready before pop", 64'(rr_c0), 64'(0));
        chk("bp ready after pop", 64'(rr_c1), 64'(1));
        chk("bp responses", 64'(ng), 64'(4));
        for (int k = 0; k < 4; k++) chk($sformatf("bp data %0d", k), 64'(got[k]), 64'(16 + k));

        for (int c = 0; c < 10000; c++) begin
          req_valid = 1'($urandom_range(0, 1));
          req_addr  = 8'($urandom);
          req_tag   = 4'($urandom);
          rsp_ready = 1'($urandom_range(0, 1));
          tick();
        end
        req_valid = 1'b0; rsp_ready = 1'b1;
        repeat (8) tick();
        @(negedge clk);
        chk("random drained busy", 64'(bz), 64'(0));
        tick();

        rsp_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
          req_valid = 1'b1; req_addr = 8'h30 + 8'(c); req_tag = 4'(c);
          tick();
        end
        chk("pre-reset busy", 64'(bz[0]), 64'(1));
        nreset = 1'b0;
        #1;
        chk("async reset rsp_valid", 64'(rv[0]), 64'(0));
        chk("async reset busy", 64'(bz[0]), 64'(0));
        chk("async reset req_ready", 64'(rr[0]), 64'(1));
        req_valid = 1'b0;
        tick();
        tick();
        nreset = 1'b1;
        tick();
        single(0, 8'h22, 4'h7, d, tg, lat, nr);
        chk("post-reset data", 64'(d), 64'h0022);
        chk("post-reset tag", 64'(tg), 64'h7);
        chk("post-reset count", 64'(nr), 64'(1));
        chk("post-reset latency", 64'(lat), 64'(2));
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
      end
    join
  end

endmodule
